seg_display_driver: RTL and testbench

- Downstream display stage for the countdown counter.
- Accepts the 8-bit binary seconds value the counter produces and converts it to three BCD digits with a sequential double-dabble converter.
- Time-multiplexes the digits onto the board's active-low 8-digit seven-segment display, driving cathode/anode directly.

---
 rtl/seg_pkg.sv | 54 +++++
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 rtl/seg_display_driver.sv | 85 ++++++++
 tb/tb_seg_display_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, state encoding and helpers for the seven-segment display driver.
package seg_pkg;

  localparam int NUM_DIGITS = 3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_e;

  // BCD nibble to segment pattern; anything outside 0..9 turns all segments off.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble iteration on {hundreds, tens, units, binary}: add-3 correction then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (adj[8 + 4*n +: 4] >= 4'd5) begin
        adj[8 + 4*n +: 4] = adj[8 + 4*n +: 4] + 4'd3;
      end
    end
    dabble_step = {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter with a one-deep pending slot.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);

  conv_state_e state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_val_q, pend_val_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;

  // Next-state logic: start/shift/commit sequencing plus capture of strobes that arrive mid-conversion.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;

    case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          // A fresh strobe takes priority over the stored value.
          sr_d    = {12'd0, (start ? bin_in : pend_val_q)};
          pend_d  = 1'b0;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // All three digits are committed together so the display never sees a partial result.
        bcd_d   = sr_q[19:8];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes while converting are remembered; a later strobe overwrites an earlier one.
    if (start && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = bin_in;
    end
  end

  // State register with synchronous active-low reset; reset abandons any conversion in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/seg_display_driver.sv
// Converts an 8-bit value to BCD and time-multiplexes three digits onto an active-low 8-digit display.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       value_valid,
  output logic       busy,
  output logic       done,
  output logic [6:0] cathode,
  output logic [7:0] anode
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [11:0] bcd;
  logic [3:0]  dig_h, dig_t, dig_u;
  logic [6:0]  seg_sel;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;

  bin2bcd_seq u_conv (
    .clock   (clock),
    .rst     (rst),
    .start   (value_valid),
    .bin_in  (value),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd)
  );

  assign dig_h = bcd[11:8];
  assign dig_t = bcd[7:4];
  assign dig_u = bcd[3:0];

  // Pick and decode the digit for the active slot, blanking leading zeros when enabled.
  always_comb begin
    seg_sel = SEG_BLANK;
    case (idx_q)
      2'd0: seg_sel = seg_decode(dig_u);
      2'd1: seg_sel = (BLANK_LZ && (dig_h == 4'd0) && (dig_t == 4'd0)) ? SEG_BLANK : seg_decode(dig_t);
      2'd2: seg_sel = (BLANK_LZ && (dig_h == 4'd0)) ? SEG_BLANK : seg_decode(dig_h);
      default: seg_sel = SEG_BLANK;
    endcase
  end

  // Scan sequencing: prescaler wrap advances the digit slot 0->1->2->0; outputs follow the current slot.
  always_comb begin
    pre_d     = pre_q + PW'(1);
    idx_d     = idx_q;
    anode_d   = ~(8'b1 << idx_q);
    cathode_d = seg_sel;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Scan registers; all display outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (!rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      anode_q   <= 8'hFF;
      cathode_q <= SEG_BLANK;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench: directed scenarios plus random strobes/resets against a transaction-level model.
module tb_seg_display_driver;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       value_valid;

  logic       busy_b, done_b, busy_n, done_n;
  logic [6:0] cath_b, cath_n;
  logic [7:0] an_b, an_n;

  always #5 clock = ~clock;

  seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .clock(clock), .rst(rst), .value(value), .value_valid(value_valid),
    .busy(busy_b), .done(done_b), .cathode(cath_b), .anode(an_b)
  );

  seg_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_n (
    .clock(clock), .rst(rst), .value(value), .value_valid(value_valid),
    .busy(busy_n), .done(done_n), .cathode(cath_n), .anode(an_n)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Segment table written from the digit/pattern list.
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_seg(input bit blank, input int v, input int idx);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (idx)
      0: exp_seg = seg_tab[u];
      1: exp_seg = (blank && h == 0 && t == 0) ? 7'h7F : seg_tab[t];
      2: exp_seg = (blank && h == 0) ? 7'h7F : seg_tab[h];
      default: exp_seg = 7'h7F;
    endcase
  endfunction

  // Model: remaining edges of the conversion in flight, a pending slot, the shown value and a scan clock.
  int         m_left = 0, m_val = 0, m_pend_val = 0, m_shown = 0, m_pre = 0, m_idx = 0;
  bit         m_pend = 0, m_busy = 0, m_done = 0;
  logic [7:0] m_an = 8'hFF;
  logic [6:0] m_cb = 7'h7F, m_cn = 7'h7F;

  task automatic model_edge();
    if (!rst) begin
      m_left = 0; m_pend = 0; m_shown = 0; m_busy = 0; m_done = 0;
      m_pre = 0; m_idx = 0; m_an = 8'hFF; m_cb = 7'h7F; m_cn = 7'h7F;
    end else begin
      m_an = ~(8'd1 << m_idx);
      m_cb = exp_seg(1'b1, m_shown, m_idx);
      m_cn = exp_seg(1'b0, m_shown, m_idx);
      if (m_pre == 3) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 3;
      end else begin
        m_pre++;
      end
      m_done = 0;
      if (m_left == 0) begin
        if (value_valid || m_pend) begin
          m_val  = value_valid ? int'(value) : m_pend_val;
          m_pend = 0;
          m_left = 9;
          m_busy = 1;
        end
      end else begin
        if (value_valid) begin
          m_pend     = 1;
          m_pend_val = int'(value);
        end
        m_left--;
        if (m_left == 0) begin
          m_shown = m_val;
          m_done  = 1;
          m_busy  = 0;
        end
      end
    end
  endtask

  // Advance one clock edge: model first (using the inputs the DUT samples), then compare #1 after the edge.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("anode_b", an_b, m_an);
    check("cath_b", cath_b, m_cb);
    check("busy_b", busy_b, m_busy);
    check("done_b", done_b, m_done);
    check("anode_n", an_n, m_an);
    check("cath_n", cath_n, m_cn);
    check("busy_n", busy_n, m_busy);
    check("done_n", done_n, m_done);
  endtask

  task automatic strobe(input logic [7:0] v);
    value = v;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
  endtask

  // Wait (bounded) for done on the blanking instance; returns edges taken after the strobe edge.
  task automatic wait_done(output int n);
    n = 0;
    while (done_b !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  // Observe a full scan rotation and capture the cathode shown in each slot.
  task automatic collect(input bit use_n, output logic [6:0] u, output logic [6:0] t, output logic [6:0] h);
    logic [7:0] a;
    logic [6:0] c;
    u = 'x; t = 'x; h = 'x;
    for (int i = 0; i < 12; i++) begin
      step();
      a = use_n ? an_n : an_b;
      c = use_n ? cath_n : cath_b;
      case (a)
        8'hFE: u = c;
        8'hFD: t = c;
        8'hFB: h = c;
        default: ;
      endcase
    end
  endtask

  initial begin
    int n, dcnt, blow;
    logic [6:0] su, st, sh;

    rst = 1'b0;
    value = '0;
    value_valid = 1'b0;
    step();
    step();
    check("rst_anode", an_b, 8'hFF);
    check("rst_cath", cath_b, 7'h7F);
    check("rst_busy", busy_b, 1'b0);
    check("rst_done", done_b, 1'b0);

    rst = 1'b1;
    step();
    check("first_anode", an_b, 8'hFE);
    check("first_cath", cath_b, 7'b1000000);

    // 59 with blanking: done after nine further edges, hundreds blank.
    strobe(8'd59);
    wait_done(n);
    check("done_latency", n, 9);
    collect(1'b0, su, st, sh);
    check("v59_units", su, 7'b0010000);
    check("v59_tens", st, 7'b0010010);
    check("v59_hund", sh, 7'h7F);

    // 255 without blanking.
    strobe(8'd255);
    wait_done(n);
    collect(1'b1, su, st, sh);
    check("v255_units", su, 7'b0010010);
    check("v255_tens", st, 7'b0010010);
    check("v255_hund", sh, 7'b0100100);

    // 0 then 7 with blanking.
    strobe(8'd0);
    wait_done(n);
    collect(1'b0, su, st, sh);
    check("v0_units", su, 7'b1000000);
    check("v0_tens", st, 7'h7F);
    check("v0_hund", sh, 7'h7F);
    strobe(8'd7);
    wait_done(n);
    collect(1'b0, su, st, sh);
    check("v7_units", su, 7'b1111000);
    check("v7_tens", st, 7'h7F);

    // Overlapping strobes: 59 at E0, 58 at E3, 57 at E5.
    strobe(8'd59);
    dcnt = 0;
    blow = 0;
    for (int e = 1; e <= 25; e++) begin
      value_valid = (e == 3 || e == 5);
      value = (e == 3) ? 8'd58 : 8'd57;
      step();
      if (done_b === 1'b1) dcnt++;
      if (e <= 18 && busy_b !== 1'b1) blow++;
    end
    value_valid = 1'b0;
    check("ovl_done_count", dcnt, 2);
    check("ovl_busy_gap", blow, 1);
    collect(1'b0, su, st, sh);
    check("v57_units", su, 7'b1111000);
    check("v57_tens", st, 7'b0010010);
    check("v57_hund", sh, 7'h7F);

    // Reset during a conversion of 200.
    strobe(8'd200);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    check("midrst_busy", busy_b, 1'b0);
    check("midrst_done", done_b, 1'b0);
    rst = 1'b1;
    step();
    check("midrst_anode", an_b, 8'hFE);
    check("midrst_cath", cath_b, 7'b1000000);
    for (int i = 0; i < 12; i++) step();

    // Random strobes, values and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      value_valid = ($urandom_range(0, 6) == 0);
      value = 8'($urandom);
      step();
    end
    rst = 1'b1;
    value_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
